// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access unit:
// size codes, FSM states, strobe patterns and lane/strobe helpers.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  // funct3[2] only selects signedness; the low two bits carry the size.
  function automatic size_t size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_t sz, input logic [1:0] off);
    case (sz)
      SZ_H:    return off[0];
      SZ_W:    return |off;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] strobes(input size_t sz, input logic [1:0] off);
    case (sz)
      SZ_B:    return STRB_B << off;
      SZ_H:    return STRB_H << {off[1], 1'b0};
      default: return STRB_W;
    endcase
  endfunction

  function automatic logic [31:0] lanes(input size_t sz, input logic [31:0] wdata);
    case (sz)
      SZ_B:    return {4{wdata[7:0]}};
      SZ_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_format.sv
// Load-data formatter: picks the addressed byte/half out of a raw bus word
// and sign- or zero-extends it. Shared with the instruction-side unit.
module mem_load_format
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_ok;

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    byte_sel = raw[{byte_off, 3'b000} +: 8];
    half_sel = byte_off[1] ? raw[31:16] : raw[15:0];
    sign_ok  = ~funct3[2];
    case (size_of(funct3))
      SZ_B:    result = {{24{byte_sel[7] & sign_ok}}, byte_sel};
      SZ_H:    result = {{16{half_sel[15] & sign_ok}}, half_sel};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: request/response bus handshake,
// pipeline stall via memReady, load formatting, misalign and bus-error flags.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exmem_memRead,
  input  logic                  exmem_memWrite,
  input  logic [ADDR_WIDTH-1:0] exmem_addr,
  input  logic [31:0]           exmem_wdata,
  input  logic [2:0]            exmem_funct3,
  output logic                  memReady,
  output logic [31:0]           mem_rdata,
  output logic                  misaligned,
  output logic                  bus_error,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_we,
  output logic [3:0]            bus_wstrb,
  output logic [31:0]           bus_wdata,
  input  logic                  bus_rvalid,
  input  logic [31:0]           bus_rdata,
  input  logic                  bus_rerr
);

  // WAIT is left after TIMEOUT_CYCLES response-less cycles.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic        lat_read;
  logic [1:0]  lat_off;
  logic [2:0]  lat_funct3;
  logic [31:0] fmt_rdata;

  logic  req;
  logic  req_mis;
  size_t req_size;

  always_comb begin
    req      = exmem_memRead | exmem_memWrite;
    req_size = size_of(exmem_funct3);
    req_mis  = req & is_misaligned(req_size, exmem_addr[1:0]);
  end

  // Stall decisions are combinational so the pipeline freezes in the request cycle;
  // both are forced inactive while reset is held.
  assign misaligned = reset & (state == ST_IDLE) & req_mis;
  assign memReady   = ~reset | (state == ST_DONE) |
                      ((state == ST_IDLE) & (~req | req_mis));

  mem_load_format u_load_format (
    .raw      (bus_rdata),
    .byte_off (lat_off),
    .funct3   (lat_funct3),
    .result   (fmt_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      lat_read   <= 1'b0;
      lat_off    <= '0;
      lat_funct3 <= '0;
      mem_rdata  <= '0;
      bus_error  <= 1'b0;
      bus_valid  <= 1'b0;
      bus_addr   <= '0;
      bus_we     <= 1'b0;
      bus_wstrb  <= '0;
      bus_wdata  <= '0;
    end else begin
      bus_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req && !req_mis) begin
            state      <= ST_REQ;
            bus_valid  <= 1'b1;
            bus_addr   <= {exmem_addr[ADDR_WIDTH-1:2], 2'b00};
            bus_we     <= ~exmem_memRead;
            bus_wstrb  <= exmem_memRead ? 4'b0000 : strobes(req_size, exmem_addr[1:0]);
            bus_wdata  <= lanes(req_size, exmem_wdata);
            lat_read   <= exmem_memRead;
            lat_off    <= exmem_addr[1:0];
            lat_funct3 <= exmem_funct3;
          end
        end
        ST_REQ: begin
          if (bus_ready) begin
            state     <= ST_WAIT;
            bus_valid <= 1'b0;
            wait_cnt  <= '0;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          // A response in the timeout cycle still wins.
          if (bus_rvalid) begin
            state     <= ST_DONE;
            bus_error <= bus_rerr;
            mem_rdata <= (lat_read && !bus_rerr) ? fmt_rdata : '0;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            state     <= ST_DONE;
            bus_error <= 1'b1;
            mem_rdata <= '0;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          mem_rdata <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level model predicts every
// output each cycle; hand-computed literals pin the model on key cases.
module tb_mem_access_unit;
  localparam int AW = 32;
  localparam int TO = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          exmem_memRead, exmem_memWrite;
  logic [AW-1:0] exmem_addr;
  logic [31:0]   exmem_wdata;
  logic [2:0]    exmem_funct3;
  logic          memReady, misaligned, bus_error, bus_valid, bus_we;
  logic          bus_ready, bus_rvalid, bus_rerr;
  logic [31:0]   mem_rdata, bus_wdata, bus_rdata;
  logic [AW-1:0] bus_addr;
  logic [3:0]    bus_wstrb;

  always #5 clock = ~clock;

  mem_access_unit #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clock          (clock),
    .reset          (reset),
    .exmem_memRead  (exmem_memRead),
    .exmem_memWrite (exmem_memWrite),
    .exmem_addr     (exmem_addr),
    .exmem_wdata    (exmem_wdata),
    .exmem_funct3   (exmem_funct3),
    .memReady       (memReady),
    .mem_rdata      (mem_rdata),
    .misaligned     (misaligned),
    .bus_error      (bus_error),
    .bus_valid      (bus_valid),
    .bus_ready      (bus_ready),
    .bus_addr       (bus_addr),
    .bus_we         (bus_we),
    .bus_wstrb      (bus_wstrb),
    .bus_wdata      (bus_wdata),
    .bus_rvalid     (bus_rvalid),
    .bus_rdata      (bus_rdata),
    .bus_rerr       (bus_rerr)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Per-cycle expectations, set half a cycle before they are compared.
  logic        chk_en = 1'b0, chk_bus = 1'b0, chk_wr = 1'b0, chk_rdata = 1'b0;
  logic        e_ready = 1'b1, e_mis = 1'b0, e_err = 1'b0, e_valid = 1'b0, e_we = 1'b0;
  logic [31:0] e_rdata = '0, e_addr = '0, e_wdata = '0;
  logic [3:0]  e_wstrb = '0;

  // Observations gathered over one access for the literal checks.
  int          last_stall;
  logic        last_err, last_mis, last_we;
  logic [31:0] last_rdata, last_addr, last_wdata;
  logic [3:0]  last_wstrb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("memReady",   32'(memReady),   32'(e_ready));
      check("misaligned", 32'(misaligned), 32'(e_mis));
      check("bus_error",  32'(bus_error),  32'(e_err));
      check("bus_valid",  32'(bus_valid),  32'(e_valid));
      if (chk_rdata) check("mem_rdata", mem_rdata, e_rdata);
      if (chk_bus) begin
        check("bus_addr", bus_addr,      e_addr);
        check("bus_we",   32'(bus_we),   32'(e_we));
      end
      if (chk_wr) begin
        check("bus_wstrb", 32'(bus_wstrb), 32'(e_wstrb));
        check("bus_wdata", bus_wdata,      e_wdata);
      end
    end
  end

  // ---- behavioural model ----
  function automatic int size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) % size_bytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
    int n = size_bytes(f3);
    int off = int'(a[1:0]);
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (size_bytes(f3))
      1:       return {4{wd[7:0]}};
      2:       return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] raw);
    int n = size_bytes(f3);
    logic [31:0] v;
    v = raw >> (8 * int'(a[1:0]));
    if (n == 1) begin
      v = v & 32'h0000_00FF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (n == 2) begin
      v = v & 32'h0000_FFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = raw;
    end
    return v;
  endfunction

  task automatic tick();
    @(negedge clock);
    if (!memReady) last_stall++;
    if (bus_error) last_err = 1'b1;
    if (misaligned) last_mis = 1'b1;
    if (memReady) last_rdata = mem_rdata;
    if (bus_valid) begin
      last_addr  = bus_addr;
      last_we    = bus_we;
      last_wstrb = bus_wstrb;
      last_wdata = bus_wdata;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic clear_obs();
    last_stall = 0;
    last_err   = 1'b0;
    last_mis   = 1'b0;
    last_we    = 1'b0;
    last_rdata = '0;
    last_addr  = '0;
    last_wdata = '0;
    last_wstrb = '0;
  endtask

  // One complete access. rdy_wait: cycles bus_ready is low; rsp_wait: WAIT cycles
  // before bus_rvalid; no_resp: never respond; stale: rvalid/rerr noise during REQ.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3,
                        input int rdy_wait, input int rsp_wait, input logic rerr,
                        input logic no_resp, input logic [31:0] raw, input logic stale);
    int n_wait;
    clear_obs();
    exmem_memRead  = rd;
    exmem_memWrite = wr;
    exmem_addr     = a;
    exmem_wdata    = wd;
    exmem_funct3   = f3;
    if (model_mis(f3, a)) begin
      e_ready = 1'b1; e_mis = 1'b1; chk_rdata = 1'b1; e_rdata = '0;
      tick();
    end else begin
      e_ready = 1'b0;
      tick();
      chk_bus = 1'b1; e_valid = 1'b1;
      e_addr  = a & 32'hFFFF_FFFC;
      e_we    = wr && !rd;
      chk_wr  = wr && !rd;
      e_wstrb = model_strb(f3, a);
      e_wdata = model_wdata(f3, wd);
      for (int i = 0; i <= rdy_wait; i++) begin
        bus_ready  = (i == rdy_wait);
        bus_rvalid = stale;
        bus_rerr   = stale;
        bus_rdata  = 32'hBAD0_BAD0;
        tick();
      end
      bus_ready = 1'b0; chk_bus = 1'b0; chk_wr = 1'b0; e_valid = 1'b0;
      n_wait = no_resp ? TO : rsp_wait + 1;
      for (int i = 0; i < n_wait; i++) begin
        bus_rvalid = !no_resp && (i == rsp_wait);
        bus_rerr   = rerr;
        bus_rdata  = raw;
        tick();
      end
      bus_rvalid = 1'b0; bus_rerr = 1'b0;
      e_ready   = 1'b1;
      e_err     = rerr || no_resp;
      chk_rdata = 1'b1;
      e_rdata   = (rd && !e_err) ? model_load(f3, a, raw) : 32'h0;
      tick();
    end
    exmem_memRead = 1'b0; exmem_memWrite = 1'b0;
    e_ready = 1'b1; e_mis = 1'b0; e_err = 1'b0; chk_rdata = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    exmem_memRead = 1'b0; exmem_memWrite = 1'b0; exmem_addr = '0;
    exmem_wdata = '0; exmem_funct3 = 3'b010;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rerr = 1'b0; bus_rdata = '0;
    clear_obs();

    // Reset values.
    chk_en = 1'b1; chk_rdata = 1'b1; chk_bus = 1'b1; chk_wr = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    chk_rdata = 1'b0; chk_bus = 1'b0; chk_wr = 1'b0;
    tick();

    // LW 0x100, zero wait.
    access(1, 0, 32'h100, 0, 3'b010, 0, 0, 0, 0, 32'hDEAD_BEEF, 0);
    check("lw_rdata", last_rdata, 32'hDEAD_BEEF);
    check("lw_stall", 32'(last_stall), 32'd3);

    // LB / LBU at 0x103.
    access(1, 0, 32'h103, 0, 3'b000, 0, 0, 0, 0, 32'h80FF_0000, 0);
    check("lb_rdata", last_rdata, 32'hFFFF_FF80);
    access(1, 0, 32'h103, 0, 3'b100, 0, 0, 0, 0, 32'h80FF_0000, 0);
    check("lbu_rdata", last_rdata, 32'h0000_0080);

    // SH 0x102.
    access(0, 1, 32'h102, 32'h0000_1234, 3'b001, 0, 0, 0, 0, 32'h0, 0);
    check("sh_wstrb", 32'(last_wstrb), 32'hC);
    check("sh_wdata", last_wdata, 32'h1234_1234);
    check("sh_addr",  last_addr,  32'h100);
    check("sh_we",    32'(last_we), 32'd1);

    // Misaligned LW 0x101.
    access(1, 0, 32'h101, 0, 3'b010, 0, 0, 0, 0, 32'h0, 0);
    check("mis_pulse", 32'(last_mis),   32'd1);
    check("mis_stall", 32'(last_stall), 32'd0);

    // Half loads, signed and unsigned, both lanes.
    access(1, 0, 32'h102, 0, 3'b001, 0, 1, 0, 0, 32'h8001_7FFF, 0);
    check("lh_rdata", last_rdata, 32'hFFFF_8001);
    access(1, 0, 32'h100, 0, 3'b101, 0, 0, 0, 0, 32'h8001_7FFF, 0);
    check("lhu_rdata", last_rdata, 32'h0000_7FFF);

    // SB with ready stalls and stale responses during REQ.
    access(0, 1, 32'h201, 32'h0000_00A5, 3'b000, 2, 0, 0, 0, 32'h0, 1);
    check("sb_wstrb", 32'(last_wstrb), 32'h2);
    check("sb_wdata", last_wdata, 32'hA5A5_A5A5);
    check("sb_stall", 32'(last_stall), 32'd5);

    // SW with a delayed ack, then read-wins-over-write.
    access(0, 1, 32'h300, 32'hCAFE_F00D, 3'b010, 0, 3, 0, 0, 32'h0, 0);
    access(1, 1, 32'h304, 32'h1111_1111, 3'b010, 0, 0, 0, 0, 32'h5555_AAAA, 0);
    check("rw_we", 32'(last_we), 32'd0);

    // Timeout: ready low 5 cycles, no response.
    access(1, 0, 32'h400, 0, 3'b010, 5, 0, 0, 1, 32'h0, 0);
    check("to_err",   32'(last_err),   32'd1);
    check("to_rdata", last_rdata,      32'h0);
    check("to_stall", 32'(last_stall), 32'd15);

    // Error response.
    access(1, 0, 32'h404, 0, 3'b010, 0, 2, 1, 0, 32'h7777_7777, 0);
    check("rerr_err",   32'(last_err), 32'd1);
    check("rerr_rdata", last_rdata,    32'h0);

    // Response in the last cycle before timeout wins.
    access(1, 0, 32'h408, 0, 3'b010, 0, TO - 1, 0, 0, 32'h0BAD_CAFE, 0);
    check("late_err",   32'(last_err),   32'd0);
    check("late_rdata", last_rdata,      32'h0BAD_CAFE);
    check("late_stall", 32'(last_stall), 32'd10);

    // Misaligned LH and SW.
    access(1, 0, 32'h103, 0, 3'b001, 0, 0, 0, 0, 32'h0, 0);
    access(0, 1, 32'h302, 32'h1, 3'b010, 0, 0, 0, 0, 32'h0, 0);

    // Reset during WAIT, then a stale response in IDLE.
    exmem_memRead = 1'b1; exmem_addr = 32'h200; exmem_funct3 = 3'b010;
    e_ready = 1'b0;
    tick();
    chk_bus = 1'b1; e_valid = 1'b1; e_addr = 32'h200; e_we = 1'b0; bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0; chk_bus = 1'b0; e_valid = 1'b0;
    tick();
    reset = 1'b0; exmem_memRead = 1'b0;
    e_ready = 1'b1; chk_rdata = 1'b1; e_rdata = '0;
    chk_bus = 1'b1; chk_wr = 1'b1; e_addr = '0; e_we = 1'b0; e_wstrb = '0; e_wdata = '0;
    tick();
    tick();
    #2 reset = 1'b1;
    chk_bus = 1'b0; chk_wr = 1'b0; chk_rdata = 1'b0;
    clear_obs();
    bus_rvalid = 1'b1; bus_rerr = 1'b1; bus_rdata = 32'h1234_5678;
    tick();
    tick();
    bus_rvalid = 1'b0; bus_rerr = 1'b0;
    check("stale_err",   32'(last_err),   32'd0);
    check("stale_stall", 32'(last_stall), 32'd0);

    // Recovery after reset.
    access(1, 0, 32'h100, 0, 3'b000, 0, 0, 0, 0, 32'h0000_00F0, 0);
    check("post_rst_lb", last_rdata, 32'hFFFF_FFF0);

    tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access controller for the 5-stage pipeline. It takes load/store requests from the EX/MEM register and runs a valid/ready request handshake plus a response handshake on the external data bus. While an access is in flight it drives `memReady` low, which the ID-stage stall control uses to freeze the pipeline. It also formats load data (byte/half extraction, sign extension) for the MEM/WB register, and flags misaligned and failed accesses.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: data-bus address width.
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent waiting for a response before the access is declared a bus error (1..255).

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `exmem_memRead`  in  1  load in the MEM stage.
- `exmem_memWrite`  in  1  store in the MEM stage. If both read and write are set, the read wins.
- `exmem_addr`  in  ADDR_WIDTH  byte address.
- `exmem_wdata`  in  32  store data (unshifted).
- `exmem_funct3`  in  3  size/sign: 000=B, 001=H, 010=W, 100=BU, 101=HU.
- `memReady`  out  1  0 = stall the pipeline; 1 = the MEM stage may advance.
- `mem_rdata`  out  32  formatted load result; valid in the `memReady` cycle that completes a load.
- `misaligned`  out  1  one-cycle pulse for a misaligned access.
- `bus_error`  out  1  one-cycle pulse on an error response or a timeout.
- `bus_valid`  out  1  request valid.
- `bus_ready`  in  1  request accepted.
- `bus_addr`  out  ADDR_WIDTH  word-aligned address (`addr[1:0]` forced to 00).
- `bus_we`  out  1  1 = write.
- `bus_wstrb`  out  4  byte strobes.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_rvalid`  in  1  response valid (read data or write ack).
- `bus_rdata`  in  32  raw read word.
- `bus_rerr`  in  1  error qualifier on `bus_rvalid`.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - No request: `memReady`=1.
  - Aligned request: `memReady`=0 combinationally; latch address, funct3, read/write, strobes and data; go to REQ.
  - Misaligned request (H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0): no bus activity, `misaligned`=1 and `memReady`=1 in the same cycle, `mem_rdata`=0, stay in IDLE.
- REQ: `bus_valid`=1 and all `bus_*` fields held stable until `bus_ready`. On handshake go to WAIT and clear the timeout counter.
- WAIT:
  - Counter increments each cycle.
  - On `bus_rvalid`, capture `bus_rdata` and `bus_rerr`, go to DONE.
  - If the counter reaches `TIMEOUT_CYCLES`, go to DONE with the error flag set.
  - `bus_rvalid` in the same cycle as the timeout: the response wins.
- DONE: `memReady`=1, registered `mem_rdata` driven, `bus_error` pulses if the error flag is set, return to IDLE. The stall unit advances EX/MEM in this cycle, so the same access is never re-issued.
- Strobes: B = `0001<<addr[1:0]`; H = `0011<<{addr[1],1'b0}`; W = `1111`.
- Write data lanes: B replicates `wdata[7:0]` ×4; H replicates `wdata[15:0]` ×2; W unchanged.
- Load formatting: select the byte/half indicated by `addr[1:0]`. B/H sign-extend, BU/HU zero-extend. A load that ends in a bus error returns `mem_rdata`=0.
- `bus_rvalid` is ignored in IDLE and REQ. This covers stale responses after a reset.

## Timing
- Reset values: state=IDLE, `memReady`=1, `bus_valid`=0, `bus_we`=0, `bus_wstrb`=0, `bus_addr`=0, `bus_wdata`=0, `mem_rdata`=0, `misaligned`=0, `bus_error`=0, counter=0.
- Minimum latency, with `bus_ready` held high and `bus_rvalid` arriving the cycle after acceptance: 4 cycles from request to `memReady`=1 (IDLE→REQ→WAIT→DONE). `memReady`=0 for exactly 3 cycles.
- Each `bus_ready` wait cycle and each response wait cycle adds one stall cycle.
- A response is never accepted in the cycle of the request handshake.
- Back-to-back accesses: the next request is sampled in the IDLE cycle after DONE.
- Reset asserted mid-access: immediate return to IDLE with outputs at reset values. No retry.

## Structure
- `constants.vh` holds: funct3 size codes, FSM state encodings, bus strobe patterns.
- `config.vh` holds: `ADDR_WIDTH` and `TIMEOUT_CYCLES` defaults.
- One combinational sub-module, `mem_load_format`: inputs raw word, `addr[1:0]`, funct3; output formatted 32-bit result. It is reused by the instruction-side unit.

## Test plan
- LW at 0x100, bus returns 0xDEADBEEF with zero wait → `memReady` low 3 cycles, `mem_rdata`=0xDEADBEEF in the 4th cycle.
- LB at 0x103 returns 0x80FF_0000 → `mem_rdata`=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x102 with `wdata`=0x1234 → `bus_wstrb`=1100, `bus_wdata`=0x12341234, `bus_we`=1, `bus_addr`=0x100.
- LW at 0x101 → `misaligned` pulses 1 cycle, `bus_valid` never asserts, `memReady` stays 1.
- `bus_ready` held low 5 cycles, then no `bus_rvalid` → stall lasts until the timeout, then `bus_error` pulses and `mem_rdata`=0. A separate error response with `bus_rerr`=1 gives the same result.
- Reset asserted in WAIT, late `bus_rvalid` arrives in IDLE → response ignored, no `bus_error`, `memReady`=1.
